shift_add_mult_ctrl: RTL and testbench

SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

---
 rtl/shift_add_mult_ctrl.sv | 122 ++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_ctrl
// Description : Sequential unsigned shift-and-add multiplier with a
//               three-state control FSM (IDLE -> RUN -> DONE -> IDLE).
//               One partial product is folded in per RUN cycle, so a
//               WIDTH x WIDTH multiply takes WIDTH RUN cycles.
// Ports       : clk      - clock, all state changes on the rising edge
//               reset_L  - synchronous active-low reset
//               start    - begin a multiply (sampled only in IDLE)
//               A, B     - unsigned multiplicand / multiplier, captured on
//                          the accepting edge only
//               ready    - FSM in IDLE
//               busy     - FSM in RUN
//               done     - one-cycle completion pulse (FSM in DONE)
//               product  - registered result of the last completed multiply
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Counter must hold the value WIDTH itself.
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q,   state_d;
    logic [WIDTH-1:0]       mcand_q,   mcand_d;
    logic [WIDTH-1:0]       mplier_q,  mplier_d;
    logic [WIDTH:0]         acc_q,     acc_d;      // {carry, upper half}
    logic [c_CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]     product_q, product_d;

    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH:0]       w_shifted;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        // The carry bit of acc_q is always zero here (the previous shift
        // moved a zero into it), so adding the full WIDTH+1-bit accumulator
        // is the same as adding the upper half and producing a carry-out.
        w_sum     = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        // {carry, upper half, multiplier} shifted right as one register.
        w_shifted = {w_sum, mplier_q} >> 1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = A;
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = c_CNT_W'(WIDTH);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d    = w_shifted[2*WIDTH:WIDTH];
                mplier_d = w_shifted[WIDTH-1:0];
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
                // Last step: the shifted register now holds the full result.
                if (cnt_q <= c_CNT_W'(1)) begin
                    product_d = w_shifted[2*WIDTH-1:0];
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult_ctrl
// Description : Self-checking bench for shift_add_mult_ctrl (WIDTH=4 and a
//               WIDTH=8 instance). Expected products come from plain a*b.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult_ctrl;

    localparam int W  = 4;
    localparam int W8 = 8;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          ready, busy, done;
    logic [2*W-1:0] product;

    logic           start8 = 1'b0;
    logic [W8-1:0]  a8 = '0;
    logic [W8-1:0]  b8 = '0;
    logic           ready8, busy8, done8;
    logic [2*W8-1:0] product8;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] last_prod = '0;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(W)) u_dut (
        .clk     (clk),
        .reset_L (reset_L),
        .start   (start),
        .A       (a_in),
        .B       (b_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    shift_add_mult_ctrl #(.WIDTH(W8)) u_dut8 (
        .clk     (clk),
        .reset_L (reset_L),
        .start   (start8),
        .A       (a8),
        .B       (b8),
        .ready   (ready8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiply from IDLE. With scramble set, start/A/B are randomised
    // throughout RUN; none of that may disturb the result or its timing.
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
        logic [2*W-1:0] exp;
        exp   = 8'(a) * 8'(b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();                                  // accepting edge
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk("busy_in_run", {ready, busy, done}, 3'b010);
            chk("product_hold_run", product, last_prod);
            if (scramble) begin
                start = 1'($urandom);
                a_in  = W'($urandom);
                b_in  = W'($urandom);
            end
            if (k != W - 1) tick();
        end
        tick();                                  // edge W after accept
        start = 1'b0;
        chk("done_pulse", {ready, busy, done}, 3'b001);
        chk("product_value", product, exp);
        last_prod = exp;
        tick();
        chk("ready_after_done", {ready, busy, done}, 3'b100);
        chk("product_hold_idle", product, last_prod);
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
        bit             scramble;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int done_pos[$];
        logic [2*W-1:0] done_prod[$];

        vecs[0] = '{a: 4'd13, b: 4'd11, exp: 8'h8F, scramble: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'hE1, scramble: 1'b0};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  exp: 8'h00, scramble: 1'b0};
        vecs[3] = '{a: 4'd13, b: 4'd11, exp: 8'h8F, scramble: 1'b1};
        vecs[4] = '{a: 4'd9,  b: 4'd0,  exp: 8'h00, scramble: 1'b1};

        // ---- reset state ---------------------------------------------------
        reset_L = 1'b0;
        start   = 1'b1;                          // reset overrides start
        tick();
        tick();
        chk("reset_outputs", {ready, busy, done}, 3'b100);
        chk("reset_product", product, 8'h00);
        start   = 1'b0;
        reset_L = 1'b1;
        tick();
        chk("idle_no_start", {ready, busy, done}, 3'b100);

        // ---- table-driven vectors -----------------------------------------
        for (int i = 0; i < 5; i++) begin
            do_mult(vecs[i].a, vecs[i].b, vecs[i].scramble);
            chk("table_vec", product, vecs[i].exp);
        end

        // ---- start held high: back-to-back --------------------------------
        start = 1'b1;
        a_in  = 4'd3;
        b_in  = 4'd5;
        tick();                                  // accept #1 at k=0
        a_in  = 4'd7;
        b_in  = 4'd6;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done) begin
                done_pos.push_back(k);
                done_prod.push_back(product);
            end
            if (k == 6) begin
                chk("b2b_second_accept", {ready, busy, done}, 3'b010);
                start = 1'b0;
            end
        end
        chk("b2b_done_count", 64'(done_pos.size()), 64'd2);
        if (done_pos.size() == 2) begin
            chk("b2b_first_pos", 64'(done_pos[0]), 64'd4);
            chk("b2b_spacing", 64'(done_pos[1] - done_pos[0]), 64'd6);
            chk("b2b_first_prod", done_prod[0], 8'h0F);
            chk("b2b_second_prod", done_prod[1], 8'h2A);
        end
        chk("b2b_end_idle", {ready, busy, done}, 3'b100);
        last_prod = 8'h2A;

        // ---- reset during the 2nd RUN cycle -------------------------------
        start = 1'b1;
        a_in  = 4'd5;
        b_in  = 4'd7;
        tick();                                  // accept
        start = 1'b0;
        tick();                                  // now in 2nd RUN cycle
        chk("pre_reset_busy", busy, 1'b1);
        reset_L = 1'b0;
        tick();
        chk("abort_outputs", {ready, busy, done}, 3'b100);
        chk("abort_product", product, 8'h00);
        last_prod = '0;
        reset_L = 1'b1;
        // First edge out of reset with start=1 must be accepted.
        do_mult(4'd6, 4'd7, 1'b0);

        // ---- exhaustive sweep, randomised mid-run noise -------------------
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_mult(W'(a), W'(b), 1'($urandom));
            end
        end

        // ---- random operands with random idle gaps ------------------------
        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
                tick();
                chk("idle_gap_ready", {ready, busy, done}, 3'b100);
                chk("idle_gap_product", product, last_prod);
            end
            do_mult(W'($urandom), W'($urandom), 1'b1);
        end

        // ---- WIDTH=8 spot check -------------------------------------------
        start8 = 1'b1;
        a8     = 8'd255;
        b8     = 8'd255;
        tick();
        start8 = 1'b0;
        a8     = 8'd0;
        b8     = 8'd0;
        chk("w8_busy", busy8, 1'b1);
        for (int k = 1; k < W8; k++) begin
            tick();
        end
        chk("w8_still_busy", busy8, 1'b1);
        tick();
        chk("w8_done", done8, 1'b1);
        chk("w8_product", product8, 16'hFE01);
        tick();
        chk("w8_ready", ready8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
